// File: rtl/coherent_memory_arbiter_pkg.sv
// Shared request layout, arbiter FSM states and onehot helper for coherent_memory_arbiter.
// Request word: {write flag, address, data}, MSB first.
package coherent_memory_arbiter_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_RESP_W = 16;
  localparam int MAX_CACHES = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } state_e;

  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int req_wr_bit(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int req_addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic logic [MAX_CACHES-1:0] onehot(input int idx);
    return {{(MAX_CACHES-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/coherent_memory_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first pending index strictly after last_i, wrapping.
// Zero latency; no flow control of its own.
module coherent_memory_arbiter_rr_arbiter #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  pending_i,
  input  logic [GW-1:0] last_i,
  output logic [GW-1:0] grant_o,
  output logic          any_o
);

  // Scan from the farthest offset down so the nearest pending index wins.
  always_comb begin
    grant_o = '0;
    for (int off = N; off >= 1; off--) begin
      int idx;
      idx = (int'(last_i) + off) % N;
      if (pending_i[idx]) grant_o = GW'(idx);
    end
  end

  assign any_o = |pending_i;

endmodule

// File: rtl/coherent_memory_arbiter.sv
// Round-robin arbiter of NUM_CACHES cache channels onto one memory port with write invalidates.
// Issue 2 cycles after strobe, 4-cycle minimum turnaround; busy channels drop new strobes, memory may stall indefinitely.
module coherent_memory_arbiter
  import coherent_memory_arbiter_pkg::*;
#(
  parameter int NUM_CACHES = 2,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RESP_W     = DEF_RESP_W,
  parameter int REQ_W      = req_width(ADDR_W, DATA_W),
  parameter int GRANT_W    = $clog2(NUM_CACHES)
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic [NUM_CACHES*REQ_W-1:0] cache_request_i,
  input  logic [NUM_CACHES-1:0]       cache_request_ready_i,
  output logic [NUM_CACHES-1:0]       cache_busy_o,
  output logic [REQ_W-1:0]            memory_request_o,
  output logic                        memory_request_ready_o,
  input  logic [RESP_W-1:0]           memory_response_i,
  input  logic                        memory_response_ready_i,
  output logic [RESP_W-1:0]           cache_response_o,
  output logic [NUM_CACHES-1:0]       cache_response_ready_o,
  output logic [ADDR_W-1:0]           invalidate_address_o,
  output logic [NUM_CACHES-1:0]       invalidate_valid_o
);

  localparam int WR_BIT   = req_wr_bit(ADDR_W, DATA_W);
  localparam int ADDR_LSB = req_addr_lsb(DATA_W);

  state_e                  state_q, state_d;
  logic [NUM_CACHES-1:0]   pending_q, pending_d;
  logic [REQ_W-1:0]        hold_q [NUM_CACHES];
  logic [REQ_W-1:0]        hold_d [NUM_CACHES];
  logic [GRANT_W-1:0]      grant_q, grant_d;
  logic [GRANT_W-1:0]      rr_q, rr_d;
  logic [REQ_W-1:0]        mreq_q, mreq_d;
  logic                    mrdy_q, mrdy_d;
  logic [RESP_W-1:0]       cresp_q, cresp_d;
  logic [NUM_CACHES-1:0]   crdy_q, crdy_d;
  logic [ADDR_W-1:0]       inv_addr_q, inv_addr_d;
  logic [NUM_CACHES-1:0]   inv_vld_q, inv_vld_d;

  logic [GRANT_W-1:0]      arb_grant;
  logic                    arb_any;
  logic [NUM_CACHES-1:0]   arb_oh, grant_oh;

  coherent_memory_arbiter_rr_arbiter #(
    .N  (NUM_CACHES),
    .GW (GRANT_W)
  ) u_rr_arbiter (
    .pending_i (pending_q),
    .last_i    (rr_q),
    .grant_o   (arb_grant),
    .any_o     (arb_any)
  );

  assign arb_oh   = NUM_CACHES'(onehot(int'(arb_grant)));
  assign grant_oh = NUM_CACHES'(onehot(int'(grant_q)));

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (arb_any) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT:    if (memory_response_ready_i) state_d = ST_RESPOND;
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output registers are loaded on the transition into the state that shows them.
  always_comb begin
    grant_d    = grant_q;
    rr_d       = rr_q;
    mreq_d     = mreq_q;
    mrdy_d     = 1'b0;
    cresp_d    = cresp_q;
    crdy_d     = '0;
    inv_addr_d = inv_addr_q;
    inv_vld_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          mreq_d  = hold_q[arb_grant];
          mrdy_d  = 1'b1;
          if (hold_q[arb_grant][WR_BIT]) begin
            inv_addr_d = hold_q[arb_grant][ADDR_LSB +: ADDR_W];
            inv_vld_d  = ~arb_oh;
          end
        end
      end
      ST_WAIT: begin
        if (memory_response_ready_i) begin
          cresp_d = memory_response_i;
          crdy_d  = grant_oh;
        end
      end
      ST_RESPOND: rr_d = grant_q;
      default: ;
    endcase
  end

  // Pending is still set during RESPOND, so a strobe there is dropped.
  always_comb begin
    pending_d = pending_q;
    hold_d    = hold_q;
    for (int i = 0; i < NUM_CACHES; i++) begin
      if (cache_request_ready_i[i] && !pending_q[i]) begin
        pending_d[i] = 1'b1;
        hold_d[i]    = cache_request_i[i*REQ_W +: REQ_W];
      end
    end
    if (state_q == ST_RESPOND) pending_d[grant_q] = 1'b0;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      pending_q  <= '0;
      for (int i = 0; i < NUM_CACHES; i++) hold_q[i] <= '0;
      grant_q    <= '0;
      rr_q       <= GRANT_W'(NUM_CACHES - 1);
      mreq_q     <= '0;
      mrdy_q     <= 1'b0;
      cresp_q    <= '0;
      crdy_q     <= '0;
      inv_addr_q <= '0;
      inv_vld_q  <= '0;
    end else begin
      pending_q  <= pending_d;
      hold_q     <= hold_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      mreq_q     <= mreq_d;
      mrdy_q     <= mrdy_d;
      cresp_q    <= cresp_d;
      crdy_q     <= crdy_d;
      inv_addr_q <= inv_addr_d;
      inv_vld_q  <= inv_vld_d;
    end
  end

  assign cache_busy_o           = pending_q;
  assign memory_request_o       = mreq_q;
  assign memory_request_ready_o = mrdy_q;
  assign cache_response_o       = cresp_q;
  assign cache_response_ready_o = crdy_q;
  assign invalidate_address_o   = inv_addr_q;
  assign invalidate_valid_o     = inv_vld_q;

endmodule

// File: tb/tb_coherent_memory_arbiter.sv
// Directed bench for coherent_memory_arbiter with four cache channels.
module tb_coherent_memory_arbiter;

  localparam int N     = 4;
  localparam int REQ_W = 25;

  logic              clock_i = 1'b0;
  logic              reset_i = 1'b1;
  logic [N*REQ_W-1:0] cache_request_i = '0;
  logic [N-1:0]      cache_request_ready_i = '0;
  logic [N-1:0]      cache_busy_o;
  logic [REQ_W-1:0]  memory_request_o;
  logic              memory_request_ready_o;
  logic [15:0]       memory_response_i = '0;
  logic              memory_response_ready_i = 1'b0;
  logic [15:0]       cache_response_o;
  logic [N-1:0]      cache_response_ready_o;
  logic [15:0]       invalidate_address_o;
  logic [N-1:0]      invalidate_valid_o;

  int errors = 0;
  int checks = 0;

  coherent_memory_arbiter #(
    .NUM_CACHES (N),
    .ADDR_W     (16),
    .DATA_W     (8),
    .RESP_W     (16),
    .REQ_W      (REQ_W),
    .GRANT_W    (2)
  ) dut (
    .clock_i                 (clock_i),
    .reset_i                 (reset_i),
    .cache_request_i         (cache_request_i),
    .cache_request_ready_i   (cache_request_ready_i),
    .cache_busy_o            (cache_busy_o),
    .memory_request_o        (memory_request_o),
    .memory_request_ready_o  (memory_request_ready_o),
    .memory_response_i       (memory_response_i),
    .memory_response_ready_i (memory_response_ready_i),
    .cache_response_o        (cache_response_o),
    .cache_response_ready_o  (cache_response_ready_o),
    .invalidate_address_o    (invalidate_address_o),
    .invalidate_valid_o      (invalidate_valid_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick;
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [15:0] addr, input logic [7:0] data);
    cache_request_i[ch*REQ_W +: REQ_W] = {wr, addr, data};
  endtask

  // One full transaction from an IDLE cycle: expect channel ch to be issued with addr.
  task automatic do_txn(input int ch, input logic [15:0] addr, input logic [15:0] data);
    int n = 0;
    logic [N-1:0] exp_oh;
    exp_oh = 4'b0001 << ch;
    tick;
    cache_request_ready_i = '0;
    while (!memory_request_ready_o && n < 12) begin
      tick;
      n++;
    end
    chk("rr_issue", memory_request_ready_o, 1);
    chk("rr_addr", memory_request_o[23:8], addr);
    tick;
    memory_response_i = data;
    memory_response_ready_i = 1'b1;
    tick;
    memory_response_ready_i = 1'b0;
    chk("rr_resp_rdy", cache_response_ready_o, exp_oh);
    chk("rr_resp_dat", cache_response_o, data);
    tick;
  endtask

  initial begin
    // Reset state
    #1 reset_i = 1'b0;
    #1;
    chk("rst_mrdy", memory_request_ready_o, 0);
    chk("rst_mreq", memory_request_o, 0);
    chk("rst_busy", cache_busy_o, 0);
    chk("rst_crdy", cache_response_ready_o, 0);
    chk("rst_cresp", cache_response_o, 0);
    chk("rst_inv_vld", invalidate_valid_o, 0);
    chk("rst_inv_addr", invalidate_address_o, 0);
    tick;
    reset_i = 1'b1;

    // Single read on ch0
    set_req(0, 1'b0, 16'h1234, 8'h00);
    cache_request_ready_i = 4'b0001;
    tick;
    cache_request_ready_i = '0;
    chk("rd_busy_c1", cache_busy_o, 4'b0001);
    chk("rd_mrdy_c1", memory_request_ready_o, 0);
    tick;
    chk("rd_mrdy_c2", memory_request_ready_o, 1);
    chk("rd_mreq_c2", memory_request_o, 25'h0123400);
    chk("rd_inv_c2", invalidate_valid_o, 0);
    tick;
    chk("rd_mrdy_c3", memory_request_ready_o, 0);
    tick;
    tick;
    chk("rd_crdy_c5", cache_response_ready_o, 0);
    memory_response_i = 16'hBEEF;
    memory_response_ready_i = 1'b1;
    tick;
    memory_response_ready_i = 1'b0;
    chk("rd_crdy_c6", cache_response_ready_o, 4'b0001);
    chk("rd_cresp_c6", cache_response_o, 16'hBEEF);
    chk("rd_busy_c6", cache_busy_o, 4'b0001);
    tick;
    chk("rd_busy_c7", cache_busy_o, 0);
    chk("rd_crdy_c7", cache_response_ready_o, 0);
    chk("rd_cresp_hold", cache_response_o, 16'hBEEF);

    // Write with invalidate from ch2
    set_req(2, 1'b1, 16'h00A0, 8'h5A);
    cache_request_ready_i = 4'b0100;
    tick;
    cache_request_ready_i = '0;
    tick;
    chk("wr_mrdy", memory_request_ready_o, 1);
    chk("wr_mreq", memory_request_o, 25'h100A05A);
    chk("wr_inv_addr", invalidate_address_o, 16'h00A0);
    chk("wr_inv_vld", invalidate_valid_o, 4'b1011);
    tick;
    chk("wr_inv_vld_wait", invalidate_valid_o, 0);
    memory_response_i = 16'h00AC;
    memory_response_ready_i = 1'b1;
    tick;
    memory_response_ready_i = 1'b0;
    chk("wr_crdy", cache_response_ready_o, 4'b0100);
    chk("wr_cresp", cache_response_o, 16'h00AC);
    tick;

    // Dropped strobe on busy ch1 plus spurious responses in IDLE and ISSUE
    set_req(1, 1'b0, 16'h1111, 8'h00);
    cache_request_ready_i = 4'b0010;
    tick;
    set_req(1, 1'b0, 16'h2222, 8'h00);
    memory_response_i = 16'h5555;
    memory_response_ready_i = 1'b1;
    tick;
    cache_request_ready_i = '0;
    chk("drop_mrdy", memory_request_ready_o, 1);
    chk("drop_mreq", memory_request_o, 25'h0111100);
    chk("spur_crdy_idle", cache_response_ready_o, 0);
    tick;
    memory_response_ready_i = 1'b0;
    chk("spur_crdy_issue", cache_response_ready_o, 0);
    chk("wait_mreq_hold", memory_request_o, 25'h0111100);
    tick;
    chk("wait_crdy", cache_response_ready_o, 0);
    memory_response_i = 16'h7777;
    memory_response_ready_i = 1'b1;
    tick;
    memory_response_ready_i = 1'b0;
    chk("drop_crdy", cache_response_ready_o, 4'b0010);
    chk("drop_cresp", cache_response_o, 16'h7777);
    tick;
    tick;
    tick;
    chk("drop_no_reissue", memory_request_ready_o, 0);
    chk("drop_busy", cache_busy_o, 0);

    // Reset during WAIT on ch3
    set_req(3, 1'b0, 16'h3333, 8'h00);
    cache_request_ready_i = 4'b1000;
    tick;
    cache_request_ready_i = '0;
    tick;
    chk("rstw_issue", memory_request_ready_o, 1);
    tick;
    reset_i = 1'b0;
    #1;
    chk("rstw_mreq", memory_request_o, 0);
    chk("rstw_busy", cache_busy_o, 0);
    chk("rstw_cresp", cache_response_o, 0);
    chk("rstw_inv_addr", invalidate_address_o, 0);
    tick;
    reset_i = 1'b1;
    memory_response_i = 16'h9999;
    memory_response_ready_i = 1'b1;
    tick;
    memory_response_ready_i = 1'b0;
    chk("rstw_no_resp", cache_response_ready_o, 0);
    chk("rstw_no_cresp", cache_response_o, 0);
    tick;
    chk("rstw_idle", memory_request_ready_o, 0);

    // Round-robin: all four strobe together, ch0 re-strobes after its response
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'hA000 + 16'(i), 8'h00);
    cache_request_ready_i = 4'b1111;
    do_txn(0, 16'hA000, 16'hD000);
    set_req(0, 1'b0, 16'hA010, 8'h00);
    cache_request_ready_i = 4'b0001;
    do_txn(1, 16'hA001, 16'hD001);
    do_txn(2, 16'hA002, 16'hD002);
    do_txn(3, 16'hA003, 16'hD003);
    do_txn(0, 16'hA010, 16'hD010);
    chk("rr_busy_end", cache_busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
